// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and types.
// Used by the pre-fold stage and by the post (octant unfold) stage.
package cordic_pkg;

    // Binary-angle constants: 2^16 units = 2*pi
    localparam logic [15:0] ANG_PI2 = 16'h4000;
    localparam logic [15:0] ANG_PI  = 16'h8000;

    // Reciprocal CORDIC gain, Q1.15 (0x4DBA / 2^15 ~ 0.6073)
    localparam logic [15:0] K_INV   = 16'h4DBA;

    // Bit positions inside the octant code q = {yneg, xneg, swap}
    localparam int SWAP = 0;
    localparam int XNEG = 1;
    localparam int YNEG = 2;

    // Stage-1 pipeline contents
    typedef struct packed {
        logic        valid;
        logic        yneg;
        logic        xneg;
        logic [15:0] mag;
        logic [15:0] ang;
    } post_s1_t;

    // Modulo-2^16 angle subtraction
    function automatic logic [15:0] ang_sub(input logic [15:0] a, input logic [15:0] b);
        return a - b;
    endfunction

endpackage

// File: rtl/post_gain.sv
// Optional CORDIC gain compensation: scaled = (mag * K_INV) >> 15.
// Purely combinational; the caller registers the result.
module post_gain
    import cordic_pkg::*;
(
    input  logic [15:0] mag,
    output logic [15:0] scaled
);

    // The product fits in 31 bits, so bits [30:15] are the truncated result
    assign scaled = 16'((32'(mag) * 32'(K_INV)) >> 15);

endmodule

// File: rtl/post.sv
// CORDIC post stage: unfolds a first-octant angle back to the full circle
// using the octant code from the pre-fold stage, and carries the magnitude.
// Two-stage pipeline with clock enable.
// Optional macro POST_MAG_SCALE_EN: applies gain compensation to the
// magnitude inside stage 1 (latency unchanged).
module post
    import cordic_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        vi,
    input  logic [15:0] mi,
    input  logic [15:0] ai,
    input  logic [2:0]  q,
    output logic        vo,
    output logic [15:0] mo,
    output logic [15:0] ao
);

    post_s1_t    s1;
    logic [15:0] mag_in;
    logic [15:0] a1_next;
    logic [15:0] a2;

`ifdef POST_MAG_SCALE_EN
    post_gain u_gain (
        .mag    (mi),
        .scaled (mag_in)
    );
`else
    assign mag_in = mi;
`endif

    // Undo the swap fold (reflection about pi/4)
    assign a1_next = q[SWAP] ? ang_sub(ANG_PI2, ai) : ai;

    // Undo the x-fold (reflection about pi/2) ahead of the stage-2 register
    assign a2 = s1.xneg ? ang_sub(ANG_PI, s1.ang) : s1.ang;

    // Stage 1: swap unfold, capture octant flags, magnitude and valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
        end else if (ena) begin
            s1.valid <= vi;
            s1.yneg  <= q[YNEG];
            s1.xneg  <= q[XNEG];
            s1.mag   <= mag_in;
            s1.ang   <= a1_next;
        end
    end

    // Stage 2: y-fold unfold (negation, wraps so -pi stays 0x8000) and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vo <= 1'b0;
            mo <= '0;
            ao <= '0;
        end else if (ena) begin
            vo <= s1.valid;
            mo <= s1.mag;
            ao <= s1.yneg ? ang_sub(16'h0000, a2) : a2;
        end
    end

endmodule

// File: tb/tb_post.sv
// Self-checking bench for post: directed vectors push expected {mo, ao}
// into a scoreboard queue; a monitor pops and compares on every new output.
module tb_post;
    import cordic_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        vi;
    logic [15:0] mi;
    logic [15:0] ai;
    logic [2:0]  q;
    logic        vo;
    logic [15:0] mo;
    logic [15:0] ao;

    logic [31:0] sb[$];
    int          vectors;
    int          miscompares;
    logic        newData;
    int          runLen;
    int          maxRun;

`ifdef POST_MAG_SCALE_EN
    localparam logic [15:0] GAIN_4000 = 16'h26DD;
`else
    localparam logic [15:0] GAIN_4000 = 16'h4000;
`endif

    post dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .vi    (vi),
        .mi    (mi),
        .ai    (ai),
        .q     (q),
        .vo    (vo),
        .mo    (mo),
        .ao    (ao)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected magnitude for a given input
    function automatic logic [15:0] expMag(input logic [15:0] m);
`ifdef POST_MAG_SCALE_EN
        logic [31:0] p;
        p = 32'(m) * 32'h4DBA;
        return p[30:15];
`else
        return m;
`endif
    endfunction

    // An output is new only after an enabled edge out of reset
    always @(posedge clk) newData = rst_n && ena;

    // Monitor: pop and compare each new valid output
    always @(negedge clk) begin
        if (rst_n && newData) begin
            if (vo) begin
                logic [31:0] exp;
                runLen++;
                if (runLen > maxRun) maxRun = runLen;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_output: got mo=%h ao=%h, expected no output", mo, ao);
                end else begin
                    exp = sb.pop_front();
                    if ({mo, ao} !== exp) begin
                        miscompares++;
                        $display("[TB] FAIL scoreboard: got mo=%h ao=%h, expected mo=%h ao=%h",
                                 mo, ao, exp[31:16], exp[15:0]);
                    end
                end
            end else begin
                runLen = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one sample with ena=1 for one edge; optionally push its expectation
    task automatic applyStimulus(input logic v, input logic [15:0] m, input logic [15:0] a,
                                 input logic [2:0] qq, input logic [15:0] expM,
                                 input logic [15:0] expA, input logic doPush);
        vi  = v;
        mi  = m;
        ai  = a;
        q   = qq;
        ena = 1'b1;
        if (v && doPush) sb.push_back({expM, expA});
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        runLen      = 0;
        maxRun      = 0;
        newData     = 1'b0;
        rst_n = 1'b0;
        ena   = 1'b0;
        vi    = 1'b0;
        mi    = '0;
        ai    = '0;
        q     = '0;

        #12;
        checkOutput("reset_vo", {15'd0, vo}, 16'h0000);
        checkOutput("reset_mo", mo, 16'h0000);
        checkOutput("reset_ao", ao, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Octant unfold and boundaries
        applyStimulus(1'b1, 16'h0000, 16'h0000, 3'b000, expMag(16'h0000), 16'h0000, 1'b1);
        applyStimulus(1'b1, 16'h1234, 16'h1000, 3'b001, expMag(16'h1234), 16'h3000, 1'b1);
        applyStimulus(1'b1, 16'h0100, 16'h1000, 3'b011, expMag(16'h0100), 16'h5000, 1'b1);
        applyStimulus(1'b1, 16'hFFFF, 16'h1000, 3'b111, expMag(16'hFFFF), 16'hB000, 1'b1);
        applyStimulus(1'b1, 16'h0001, 16'h0000, 3'b010, expMag(16'h0001), 16'h8000, 1'b1);
        applyStimulus(1'b1, 16'h0002, 16'h0000, 3'b110, expMag(16'h0002), 16'h8000, 1'b1);
        applyStimulus(1'b1, 16'h0003, 16'h2000, 3'b001, expMag(16'h0003), 16'h2000, 1'b1);
        applyStimulus(1'b1, 16'h0004, 16'h2000, 3'b000, expMag(16'h0004), 16'h2000, 1'b1);
        applyStimulus(1'b1, 16'h0005, 16'h3000, 3'b001, expMag(16'h0005), 16'h1000, 1'b1);
        applyStimulus(1'b1, 16'h4000, 16'h0000, 3'b000, GAIN_4000,        16'h0000, 1'b1);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 3'b000, 16'h0000,         16'h0000, 1'b0);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 3'b000, 16'h0000,         16'h0000, 1'b0);

        // Latency with a disabled edge in the middle
        applyStimulus(1'b1, 16'h0100, 16'h0800, 3'b000, expMag(16'h0100), 16'h0800, 1'b1);
        checkOutput("lat_edge0_vo", {15'd0, vo}, 16'h0000);
        vi  = 1'b0;
        ena = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("lat_edge1_vo", {15'd0, vo}, 16'h0000);
        ena = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("lat_edge2_vo", {15'd0, vo}, 16'h0001);
        checkOutput("lat_edge2_ao", ao, 16'h0800);
        ena = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("hold_vo", {15'd0, vo}, 16'h0001);
        checkOutput("hold_ao", ao, 16'h0800);
        checkOutput("hold_mo", mo, expMag(16'h0100));
        applyStimulus(1'b0, 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0000, 1'b0);
        checkOutput("bubble_vo", {15'd0, vo}, 16'h0000);

        // Back-to-back throughput
        maxRun = 0;
        applyStimulus(1'b1, 16'h1001, 16'h0400, 3'b000, expMag(16'h1001), 16'h0400, 1'b1);
        applyStimulus(1'b1, 16'h1002, 16'h0400, 3'b001, expMag(16'h1002), 16'h3C00, 1'b1);
        applyStimulus(1'b1, 16'h1003, 16'h0400, 3'b010, expMag(16'h1003), 16'h7C00, 1'b1);
        applyStimulus(1'b1, 16'h1004, 16'h0400, 3'b011, expMag(16'h1004), 16'h4400, 1'b1);
        applyStimulus(1'b1, 16'h1005, 16'h0400, 3'b100, expMag(16'h1005), 16'hFC00, 1'b1);
        applyStimulus(1'b1, 16'h1006, 16'h0400, 3'b101, expMag(16'h1006), 16'hC400, 1'b1);
        applyStimulus(1'b1, 16'h1007, 16'h0400, 3'b110, expMag(16'h1007), 16'h8400, 1'b1);
        applyStimulus(1'b1, 16'h1008, 16'h0400, 3'b111, expMag(16'h1008), 16'hBC00, 1'b1);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0000, 1'b0);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0000, 1'b0);
        checkOutput("throughput_run", 16'(maxRun), 16'd8);

        // Reset with two samples in flight; neither may emerge
        applyStimulus(1'b1, 16'h7777, 16'h1000, 3'b001, 16'h0000, 16'h0000, 1'b0);
        applyStimulus(1'b1, 16'h8888, 16'h1000, 3'b011, 16'h0000, 16'h0000, 1'b0);
        vi = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_vo", {15'd0, vo}, 16'h0000);
        checkOutput("midreset_mo", mo, 16'h0000);
        checkOutput("midreset_ao", ao, 16'h0000);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0000, 1'b0);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0000, 1'b0);
        checkOutput("postreset_vo", {15'd0, vo}, 16'h0000);
        applyStimulus(1'b1, 16'h0042, 16'h1000, 3'b111, expMag(16'h0042), 16'hB000, 1'b1);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0000, 1'b0);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            applyStimulus(1'b0, 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0000, 1'b0);
        end
        @(negedge clk);
        checkOutput("scoreboard_empty", 16'(sb.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog against a hung run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/post.md
POST -- requirements
Module: post

Interface
REQ-001 SHALL have port clk, input, 1: single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port ena, input, 1: clock enable; pipeline advances only when ena=1.
REQ-004 SHALL have port vi, input, 1: input sample valid.
REQ-005 SHALL have port mi, input, 16: unsigned first-octant magnitude from the CORDIC core.
REQ-006 SHALL have port ai, input, 16: unsigned first-octant angle, binary-angle units (2^16 = 2*pi), legal range 0x0000..0x2000.
REQ-007 SHALL have port q, input, 3: octant code {yneg, xneg, swap} produced by the pre-fold stage for the same sample.
REQ-008 SHALL have port vo, output, 1: output sample valid.
REQ-009 SHALL have port mo, output, 16: unsigned magnitude.
REQ-010 SHALL have port ao, output, 16: signed full-circle angle, binary-angle units (0x4000 = pi/2, 0x8000 = -pi).

Function
REQ-011 SHALL be a 2-stage pipeline: input sample accepted on edge N with ena=1 appears on outputs after edge N+1 with ena=1 (latency 2 enabled edges).
REQ-012 SHALL, on an edge with ena=0, hold every register, including vo.
REQ-013 SHALL, in stage 1, register a1 = 0x4000 - ai when q[0]=1, else a1 = ai; carry yneg, xneg, magnitude and vi.
REQ-014 SHALL, in stage 2, form a2 = 0x8000 - a1 when xneg=1, else a2 = a1; drive ao = (0 - a2) mod 2^16 when yneg=1, else ao = a2.
REQ-015 SHALL use modulo-2^16 wrap arithmetic for all angle operations; a2 = 0x8000 with yneg=1 yields ao = 0x8000 (-pi), no saturation.
REQ-016 SHALL pass vi through the pipeline as vo with matching latency; data registers update regardless of vi, so bubbles propagate as vo=0.
REQ-017 SHALL treat ai > 0x2000 as don't-care input; the output is the arithmetic result of REQ-013/014 without error flagging.
REQ-018 SHALL produce ao = 0 and mo = 0 for mi=0, ai=0, q=000.

Reset
REQ-019 SHALL, when rst_n=0, asynchronously clear all pipeline registers, so vo=0, mo=0, ao=0, independent of clk and ena.
REQ-020 SHALL discard in-flight samples on reset mid-operation; the first vo=1 after rst_n rises corresponds to a sample accepted after release.

Configuration
REQ-021 SHALL use macro POST_MAG_SCALE_EN to control CORDIC gain compensation.
REQ-022 SHALL, with POST_MAG_SCALE_EN defined, compute mo = (mi * 0x4DBA) >> 15, truncated to 16 bits, registered inside the existing 2 stages (latency unchanged).
REQ-023 SHALL, without POST_MAG_SCALE_EN, deliver mo = mi delayed 2 enabled edges, with no multiplier instantiated.

Structure
REQ-024 SHALL place the constants ANG_PI2=0x4000, ANG_PI=0x8000, K_INV=0x4DBA and the q bit indices (SWAP=0, XNEG=1, YNEG=2) in shared package cordic_pkg, used by both the pre-fold and post stages.
REQ-025 SHALL isolate the optional gain multiplier in sub-module post_gain, instantiated only under POST_MAG_SCALE_EN.

Verification
REQ-026 SHALL verify octant unfold: ai=0x1000, q=001 -> ao=0x3000; q=011 -> ao=0x5000; q=111 -> ao=0xB000.
REQ-027 SHALL verify the boundary case: ai=0x0000, q=010 -> ao=0x8000; q=110 -> ao=0x8000; ai=0x2000, q=001 -> ao=0x2000.
REQ-028 SHALL verify latency/enable: vi pulse on edge 0, ena held 0 on edge 1 -> vo rises only after edge 2, and outputs hold while ena=0.
REQ-029 SHALL verify reset mid-stream: rst_n=0 asynchronously between edges with 2 valid samples in flight -> vo, mo, ao are 0 immediately, and no stale sample emerges after release.
REQ-030 SHALL verify gain: mi=0x4000 -> mo=0x26DD with POST_MAG_SCALE_EN defined, mo=0x4000 without it.
REQ-031 SHALL verify back-to-back throughput: 8 consecutive valid samples with ena=1 -> 8 consecutive vo=1 outputs in order, with no gaps.
